// File: rtl/mem_read_unit.sv
// Memory-read sequencer for the register-file writeback path: one or two byte
// reads on the external byte bus, then a single-cycle writeback presentation.

package register_types;
    typedef enum logic [3:0] {
        NONE = 4'd0,
        OP0  = 4'd1,
        OP1  = 4'd2,
        AX   = 4'd3,
        BX   = 4'd4,
        CX   = 4'd5,
        DX   = 4'd6,
        SP   = 4'd7,
        BP   = 4'd8,
        SI   = 4'd9,
        DI   = 4'd10
    } name;
endpackage

module mem_read_unit #(
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_word,
    input  register_types::name req_dest,
    output logic                bus_rd,
    output logic [ADDR_W-1:0]   bus_addr,
    input  logic                bus_ack,
    input  logic [7:0]          bus_rdata,
    output register_types::name mem_dest_select,
    output logic [7:0]          mem_dest,
    output logic [7:0]          mem_dest_hi,
    output logic                done,
    output logic                err,
    output logic                busy
);

    // Timer runs 0..TIMEOUT-1; the last value plus a missing ack means timeout.
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                word_q, word_d;
    register_types::name dest_q, dest_d;
    logic [7:0]          lo_q, lo_d;
    logic [7:0]          hi_q, hi_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    logic                req_ready_q, req_ready_d;
    logic                bus_rd_q, bus_rd_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    register_types::name sel_q, sel_d;
    logic [7:0]          mem_dest_q, mem_dest_d;
    logic [7:0]          mem_dest_hi_q, mem_dest_hi_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic                timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TMR_LAST);

    // Next-state and next-output logic; outputs follow the next state so they
    // line up with the state register.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        dest_d  = dest_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        timer_d = timer_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    word_d  = req_word;
                    dest_d  = req_dest;
                    lo_d    = 8'h00;
                    hi_d    = 8'h00;
                    timer_d = '0;
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                // Ack wins over a timeout landing in the same cycle.
                if (bus_ack) begin
                    lo_d    = bus_rdata;
                    timer_d = '0;
                    state_d = word_q ? RD_HI : WB;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            RD_HI: begin
                if (bus_ack) begin
                    hi_d    = bus_rdata;
                    state_d = WB;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d   = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        bus_rd_d      = (state_d == RD_LO) || (state_d == RD_HI);
        bus_addr_d    = '0;
        if (state_d == RD_LO) begin
            bus_addr_d = addr_d;
        end else if (state_d == RD_HI) begin
            bus_addr_d = addr_d + ADDR_W'(1);
        end
        done_d        = (state_d == WB);
        sel_d         = (state_d == WB) ? dest_d : register_types::NONE;
        mem_dest_d    = (state_d == WB) ? lo_d : 8'h00;
        mem_dest_hi_d = (state_d == WB) ? hi_d : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            word_q        <= 1'b0;
            dest_q        <= register_types::NONE;
            lo_q          <= 8'h00;
            hi_q          <= 8'h00;
            timer_q       <= '0;
            req_ready_q   <= 1'b1;
            bus_rd_q      <= 1'b0;
            bus_addr_q    <= '0;
            sel_q         <= register_types::NONE;
            mem_dest_q    <= 8'h00;
            mem_dest_hi_q <= 8'h00;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            word_q        <= word_d;
            dest_q        <= dest_d;
            lo_q          <= lo_d;
            hi_q          <= hi_d;
            timer_q       <= timer_d;
            req_ready_q   <= req_ready_d;
            bus_rd_q      <= bus_rd_d;
            bus_addr_q    <= bus_addr_d;
            sel_q         <= sel_d;
            mem_dest_q    <= mem_dest_d;
            mem_dest_hi_q <= mem_dest_hi_d;
            done_q        <= done_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign bus_rd          = bus_rd_q;
    assign bus_addr        = bus_addr_q;
    assign mem_dest_select = sel_q;
    assign mem_dest        = mem_dest_q;
    assign mem_dest_hi     = mem_dest_hi_q;
    assign done            = done_q;
    assign err             = err_q;
    assign busy            = busy_q;

endmodule
